// File: rtl/fcpu_pkg.sv
// Shared CPU types: reorder-buffer station entry, commit classification and
// commit-unit FSM encoding.
package fcpu_pkg;

  localparam int RSV_ID_W   = 4;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int OPCODE_W   = 4;

  localparam logic [OPCODE_W-1:0] OP_ADD    = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_SUB    = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_AND    = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_OR     = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_NOP    = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_HALT   = 4'd15;

  typedef struct packed {
    logic [RSV_ID_W-1:0]   station_id;
    logic                  valid;
    logic                  ready;
    logic [REG_ADDR_W-1:0] dst_reg;
    logic [OPCODE_W-1:0]   opcode;
    logic [DATA_W-1:0]     content;
    logic                  invalidate;
  } station_t;

  typedef enum logic [1:0] {C_REG, C_STORE, C_NONE, C_HALT} commit_class_t;

  typedef enum logic [1:0] {RUN, STORE_WAIT, HALTED} cu_state_t;

  // Unlisted opcodes retire without architectural side effects.
  function automatic commit_class_t commit_class(input logic [OPCODE_W-1:0] op);
    commit_class_t c;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LOAD: c = C_REG;
      OP_STORE:                               c = C_STORE;
      OP_HALT:                                c = C_HALT;
      default:                                c = C_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/commit_unit_if.sv
// Signal bundle around the commit unit: ROB head handshake, register-file
// write port and store-release handshake.
interface commit_unit_if
  import fcpu_pkg::*;
#(
  parameter int COMMIT_CNT_W = 32
) ();
  logic                    i_valid;
  station_t                i_commit_data;
  logic                    i_ready;
  logic                    o_reg_we;
  logic [REG_ADDR_W-1:0]   o_reg_addr;
  logic [DATA_W-1:0]       o_reg_data;
  logic [RSV_ID_W-1:0]     o_reg_rsv_id;
  logic                    o_store_valid;
  logic [RSV_ID_W-1:0]     o_store_id;
  logic                    o_store_ready;
  logic                    o_halt;
  logic [COMMIT_CNT_W-1:0] o_commit_count;

  // master: ROB / store buffer side; slave: commit unit side
  modport master (
    output i_valid, i_commit_data, o_store_ready,
    input  i_ready, o_reg_we, o_reg_addr, o_reg_data, o_reg_rsv_id,
           o_store_valid, o_store_id, o_halt, o_commit_count
  );
  modport slave (
    input  i_valid, i_commit_data, o_store_ready,
    output i_ready, o_reg_we, o_reg_addr, o_reg_data, o_reg_rsv_id,
           o_store_valid, o_store_id, o_halt, o_commit_count
  );
endinterface

// File: rtl/commit_unit.sv
// In-order commit stage: retires the ROB head, writes the register file,
// releases committed stores and latches halt.
module commit_unit
  import fcpu_pkg::*;
#(
  parameter int COMMIT_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    i_valid,
  input  station_t                i_commit_data,
  output logic                    i_ready,
  output logic                    o_reg_we,
  output logic [REG_ADDR_W-1:0]   o_reg_addr,
  output logic [DATA_W-1:0]       o_reg_data,
  output logic [RSV_ID_W-1:0]     o_reg_rsv_id,
  output logic                    o_store_valid,
  output logic [RSV_ID_W-1:0]     o_store_id,
  input  logic                    o_store_ready,
  output logic                    o_halt,
  output logic [COMMIT_CNT_W-1:0] o_commit_count
);

  cu_state_t               state_q;
  logic                    reg_we_q;
  logic [REG_ADDR_W-1:0]   reg_addr_q;
  logic [DATA_W-1:0]       reg_data_q;
  logic [RSV_ID_W-1:0]     reg_rsv_q;
  logic                    store_vld_q;
  logic [RSV_ID_W-1:0]     store_id_q;
  logic                    halt_q;
  logic [COMMIT_CNT_W-1:0] cnt_q;

  logic          commit;
  commit_class_t cls;
  logic          unused_ok;

  assign i_ready = (state_q == RUN);
  assign commit  = i_valid && i_ready && !i_commit_data.invalidate;
  assign cls     = commit_class(i_commit_data.opcode);

  // Entry valid/ready flags are already folded into i_valid by the ROB.
  assign unused_ok = &{1'b0, i_commit_data.valid, i_commit_data.ready};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= RUN;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      reg_rsv_q   <= '0;
      store_vld_q <= 1'b0;
      store_id_q  <= '0;
      halt_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      reg_we_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (commit) begin
            cnt_q <= cnt_q + COMMIT_CNT_W'(1);
            case (cls)
              C_REG: begin
                // r0 is hardwired; the entry still retires and counts
                if (i_commit_data.dst_reg != '0) begin
                  reg_we_q   <= 1'b1;
                  reg_addr_q <= i_commit_data.dst_reg;
                  reg_data_q <= i_commit_data.content;
                  reg_rsv_q  <= i_commit_data.station_id;
                end
              end
              C_STORE: begin
                state_q     <= STORE_WAIT;
                store_vld_q <= 1'b1;
                store_id_q  <= i_commit_data.station_id;
              end
              C_HALT: begin
                state_q <= HALTED;
                halt_q  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        STORE_WAIT: begin
          if (o_store_ready) begin
            state_q     <= RUN;
            store_vld_q <= 1'b0;
          end
        end
        HALTED: ;
        default: state_q <= RUN;
      endcase
    end
  end

  assign o_reg_we       = reg_we_q;
  assign o_reg_addr     = reg_addr_q;
  assign o_reg_data     = reg_data_q;
  assign o_reg_rsv_id   = reg_rsv_q;
  assign o_store_valid  = store_vld_q;
  assign o_store_id     = store_id_q;
  assign o_halt         = halt_q;
  assign o_commit_count = cnt_q;

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: directed vector table, multi-cycle
// halt/reset/wrap sequences and a randomized run against a reference model.
module tb_commit_unit;
  import fcpu_pkg::*;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  commit_unit_if #(.COMMIT_CNT_W(CW)) cif ();

  commit_unit #(.COMMIT_CNT_W(CW)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .i_valid        (cif.i_valid),
    .i_commit_data  (cif.i_commit_data),
    .i_ready        (cif.i_ready),
    .o_reg_we       (cif.o_reg_we),
    .o_reg_addr     (cif.o_reg_addr),
    .o_reg_data     (cif.o_reg_data),
    .o_reg_rsv_id   (cif.o_reg_rsv_id),
    .o_store_valid  (cif.o_store_valid),
    .o_store_id     (cif.o_store_id),
    .o_store_ready  (cif.o_store_ready),
    .o_halt         (cif.o_halt),
    .o_commit_count (cif.o_commit_count)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic we, input logic [4:0] addr,
                         input logic [31:0] data, input logic [3:0] rsv, input logic sv,
                         input logic [3:0] sid, input logic rdy, input logic halt,
                         input logic [3:0] cnt);
    chk({tag, ".we"},    64'(cif.o_reg_we),       64'(we));
    chk({tag, ".addr"},  64'(cif.o_reg_addr),     64'(addr));
    chk({tag, ".data"},  64'(cif.o_reg_data),     64'(data));
    chk({tag, ".rsv"},   64'(cif.o_reg_rsv_id),   64'(rsv));
    chk({tag, ".sv"},    64'(cif.o_store_valid),  64'(sv));
    chk({tag, ".sid"},   64'(cif.o_store_id),     64'(sid));
    chk({tag, ".rdy"},   64'(cif.i_ready),        64'(rdy));
    chk({tag, ".halt"},  64'(cif.o_halt),         64'(halt));
    chk({tag, ".cnt"},   64'(cif.o_commit_count), 64'(cnt));
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] dst,
                       input logic [31:0] dat, input logic [3:0] id, input logic inv,
                       input logic sr);
    station_t s;
    s = '0;
    s.station_id = id; s.valid = v; s.ready = v; s.dst_reg = dst;
    s.opcode = op; s.content = dat; s.invalidate = inv;
    cif.i_valid = v;
    cif.i_commit_data = s;
    cif.o_store_ready = sr;
  endtask

  typedef struct {
    logic v; logic [3:0] op; logic [4:0] dst; logic [31:0] dat; logic [3:0] id;
    logic inv; logic sr;
    logic e_we; logic [4:0] e_addr; logic [31:0] e_data; logic [3:0] e_rsv;
    logic e_sv; logic [3:0] e_sid; logic e_rdy; logic [3:0] e_cnt;
  } vec_t;

  vec_t tbl[16];

  // reference model state (what outputs should read after the next edge)
  logic        m_store, m_halt, e_we, e_sv;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  logic [3:0]  e_rsv, e_sid, m_cnt;
  int          halt_age;

  task automatic model_reset();
    m_store = 0; m_halt = 0; e_we = 0; e_sv = 0; e_addr = 0; e_data = 0;
    e_rsv = 0; e_sid = 0; m_cnt = 0; halt_age = 0;
  endtask

  initial begin
    drive(0, OP_NOP, 0, 0, 0, 0, 0);
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    nrst = 1'b1;

    //        v  op        dst  dat           id inv sr | we addr data          rsv sv sid rdy cnt
    tbl[0]  = '{1, OP_ADD,    5, 32'hDEADBEEF, 3, 0, 0,  1, 5,  32'hDEADBEEF, 3,  0, 0, 1, 1};
    tbl[1]  = '{0, OP_ADD,    9, 32'h12345678, 1, 0, 0,  0, 5,  32'hDEADBEEF, 3,  0, 0, 1, 1};
    tbl[2]  = '{1, OP_ADD,    7, 32'h1,        4, 1, 0,  0, 5,  32'hDEADBEEF, 3,  0, 0, 1, 1};
    tbl[3]  = '{1, OP_SUB,    2, 32'h22,       5, 0, 0,  1, 2,  32'h22,       5,  0, 0, 1, 2};
    tbl[4]  = '{1, OP_AND,    0, 32'h99,       6, 0, 0,  0, 2,  32'h22,       5,  0, 0, 1, 3};
    tbl[5]  = '{1, OP_NOP,    3, 32'h55,       2, 0, 0,  0, 2,  32'h22,       5,  0, 0, 1, 4};
    tbl[6]  = '{1, OP_ADD,   10, 32'hA0,       8, 0, 0,  1, 10, 32'hA0,       8,  0, 0, 1, 5};
    tbl[7]  = '{1, OP_OR,    11, 32'hA1,       9, 0, 0,  1, 11, 32'hA1,       9,  0, 0, 1, 6};
    tbl[8]  = '{1, OP_LOAD,  12, 32'hA2,      10, 0, 0,  1, 12, 32'hA2,      10,  0, 0, 1, 7};
    tbl[9]  = '{1, OP_SUB,   13, 32'hA3,      11, 0, 0,  1, 13, 32'hA3,      11,  0, 0, 1, 8};
    tbl[10] = '{1, OP_STORE,  4, 32'h77,       7, 0, 0,  0, 13, 32'hA3,      11,  1, 7, 0, 9};
    tbl[11] = '{1, OP_ADD,    1, 32'hF1,      12, 0, 0,  0, 13, 32'hA3,      11,  1, 7, 0, 9};
    tbl[12] = '{1, OP_ADD,    1, 32'hF2,      13, 0, 0,  0, 13, 32'hA3,      11,  1, 7, 0, 9};
    tbl[13] = '{1, OP_STORE,  1, 32'hF3,      14, 0, 0,  0, 13, 32'hA3,      11,  1, 7, 0, 9};
    tbl[14] = '{1, OP_ADD,    1, 32'hF4,      12, 0, 1,  0, 13, 32'hA3,      11,  0, 7, 1, 9};
    tbl[15] = '{1, OP_NOP,    0, 32'h0,        0, 0, 0,  0, 13, 32'hA3,      11,  0, 7, 1, 10};

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].op, tbl[i].dst, tbl[i].dat, tbl[i].id, tbl[i].inv, tbl[i].sr);
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), tbl[i].e_we, tbl[i].e_addr, tbl[i].e_data,
              tbl[i].e_rsv, tbl[i].e_sv, tbl[i].e_sid, tbl[i].e_rdy, 0, tbl[i].e_cnt);
    end

    // halt, then a valid head held: nothing further retires
    @(negedge clk);
    drive(1, OP_HALT, 0, 0, 1, 0, 1);
    @(posedge clk); #1;
    chk_all("halt", 0, 13, 32'hA3, 11, 0, 7, 0, 1, 11);
    @(negedge clk);
    drive(1, OP_ADD, 3, 32'hBAD, 2, 0, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk_all($sformatf("halted%0d", i), 0, 13, 32'hA3, 11, 0, 7, 0, 1, 11);
    end
    @(negedge clk);
    drive(0, OP_NOP, 0, 0, 0, 0, 0);
    #2 nrst = 1'b0;
    #1 chk_all("halt_rst", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk); nrst = 1'b1;
    @(posedge clk); #1;
    chk_all("after_rst", 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // reset aborts a pending store release
    @(negedge clk);
    drive(1, OP_STORE, 0, 32'h5, 9, 0, 0);
    @(posedge clk); #1;
    chk_all("st_pend", 0, 0, 0, 0, 1, 9, 0, 0, 1);
    @(negedge clk);
    drive(0, OP_NOP, 0, 0, 0, 0, 0);
    #2 nrst = 1'b0;
    #1 chk_all("st_rst", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk); nrst = 1'b1;
    drive(0, OP_NOP, 0, 0, 0, 0, 1);
    repeat (2) begin
      @(posedge clk); #1;
      chk_all("st_abort", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    end

    // counter wrap at 4 bits: 17 commits -> 1
    @(negedge clk);
    drive(1, OP_NOP, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk); #1;
      if (i >= 15) chk($sformatf("wrap%0d", i), 64'(cif.o_commit_count), 64'(i % 16));
    end
    @(negedge clk);
    drive(0, OP_NOP, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("wrap_final", 64'(cif.o_commit_count), 64'd1);

    // randomized run against the reference model
    @(negedge clk);
    nrst = 1'b0;
    #2 nrst = 1'b1;
    model_reset();
    for (int i = 0; i < 400; i++) begin
      logic v, inv, sr, acc;
      logic [3:0] op, id;
      logic [4:0] dst;
      logic [31:0] dat;
      @(negedge clk);
      chk_all("rnd", e_we, e_addr, e_data, e_rsv, e_sv, e_sid, !m_store && !m_halt, m_halt, m_cnt);
      if (m_halt && ++halt_age > 3) begin
        nrst = 1'b0;
        #1 nrst = 1'b1;
        model_reset();
      end
      v   = ($urandom_range(0, 3) != 0);
      op  = ($urandom_range(0, 99) < 2) ? OP_HALT : 4'($urandom_range(0, 14));
      dst = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      dat = $urandom;
      id  = 4'($urandom_range(0, 15));
      inv = ($urandom_range(0, 3) == 0);
      sr  = $urandom_range(0, 1) == 1;
      drive(v, op, dst, dat, id, inv, sr);

      acc  = v && !m_store && !m_halt;
      e_we = 0;
      if (m_store && sr) begin m_store = 0; e_sv = 0; end
      if (acc && !inv) begin
        m_cnt = m_cnt + 4'd1;
        if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LOAD}) begin
          if (dst != 0) begin e_we = 1; e_addr = dst; e_data = dat; e_rsv = id; end
        end else if (op == OP_STORE) begin
          m_store = 1; e_sv = 1; e_sid = id;
        end else if (op == OP_HALT) begin
          m_halt = 1;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/commit_unit.md
COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 SHALL have parameter COMMIT_CNT_W, default 32, width of the committed-instruction counter.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_valid  input  1  head entry complete and ready to commit.
REQ-005 SHALL have port i_commit_data  input  station_t  head reorder-buffer entry (station_id, valid, ready, dst_reg, opcode, content, invalidate).
REQ-006 SHALL have port i_ready  output  1  commit unit accepts the head entry this cycle.
REQ-007 SHALL have port o_reg_we  output  1  register-file write strobe.
REQ-008 SHALL have port o_reg_addr  output  REG_ADDR_W  write address (dst_reg).
REQ-009 SHALL have port o_reg_data  output  DATA_W  write data (content).
REQ-010 SHALL have port o_reg_rsv_id  output  RSV_ID_W  committing station_id, used by the register file to clear a matching rename tag.
REQ-011 SHALL have port o_store_valid  output  1  release request for a committed store.
REQ-012 SHALL have port o_store_id  output  RSV_ID_W  station_id of the store being released.
REQ-013 SHALL have port o_store_ready  input  1  store buffer accepts the release.
REQ-014 SHALL have port o_halt  output  1  halt instruction committed.
REQ-015 SHALL have port o_commit_count  output  COMMIT_CNT_W  count of architecturally committed entries.

Function
REQ-016 SHALL classify opcode via package function commit_class() into C_REG, C_STORE, C_NONE, C_HALT.
REQ-017 SHALL implement FSM states RUN, STORE_WAIT, HALTED; reset state RUN.
REQ-018 SHALL drive i_ready = 1 only in RUN; handshake = i_valid && i_ready.
REQ-019 SHALL, on handshake with invalidate=1, discard the entry: no write, no store release, no halt, no count.
REQ-020 SHALL, on handshake of C_REG with dst_reg != 0, pulse o_reg_we for exactly one cycle, the cycle after the handshake, with o_reg_addr/o_reg_data/o_reg_rsv_id registered from the entry.
REQ-021 SHALL suppress o_reg_we when dst_reg == 0 but still count the entry.
REQ-022 SHALL, on handshake of C_STORE, go to STORE_WAIT next cycle with o_store_valid=1 and o_store_id registered, held stable until o_store_ready.
REQ-023 SHALL leave STORE_WAIT for RUN the cycle after o_store_valid && o_store_ready; o_store_valid deasserts in that same next cycle.
REQ-024 SHALL, on handshake of C_HALT, enter HALTED; o_halt=1 and i_ready=0 until reset.
REQ-025 SHALL, on handshake of C_NONE, only count.
REQ-026 SHALL increment o_commit_count by 1, registered, for every non-invalidated handshake; wraps modulo 2**COMMIT_CNT_W.
REQ-027 SHALL sustain one commit per cycle for back-to-back C_REG/C_NONE entries.
REQ-028 SHALL ignore i_commit_data whenever no handshake occurs.

Reset
REQ-029 SHALL, while nrst=0, force state RUN, o_reg_we=0, o_reg_addr=0, o_reg_data=0, o_reg_rsv_id=0, o_store_valid=0, o_store_id=0, o_halt=0, o_commit_count=0.
REQ-030 SHALL abort a pending STORE_WAIT or HALTED on reset assertion without emitting further strobes.

Structure
REQ-031 SHALL place commit_class_t and commit_class() in fcpu_pkg alongside station_t.
REQ-032 SHALL be a single module without sub-modules.

Verification
REQ-033 SHALL test: C_REG dst_reg=5 content=0xDEADBEEF id=3 -> next cycle o_reg_we=1 addr=5 data=0xDEADBEEF rsv_id=3, count=1.
REQ-034 SHALL test: C_STORE id=7, o_store_ready low 3 cycles -> i_ready=0, o_store_valid held with id=7 for 4 cycles, RUN the cycle after handshake.
REQ-035 SHALL test: invalidate=1 C_REG then C_REG dst_reg=2 -> only one write (addr 2), count=1.
REQ-036 SHALL test: 4 back-to-back C_REG entries -> 4 consecutive o_reg_we pulses, count=4.
REQ-037 SHALL test: C_HALT then i_valid held -> o_halt=1, i_ready=0, no further writes; nrst pulse -> all outputs 0, RUN.
REQ-038 SHALL test: COMMIT_CNT_W=4, 17 commits -> o_commit_count=1.
